// File: rtl/rpn_checker_if.sv
// Token handshake between the player-input logic (master) and the RPN answer checker (slave).
interface rpn_checker_if;
    logic       tok_valid;
    logic       tok_ready;
    logic       tok_type;
    logic [1:0] tok_arg;

    modport master (output tok_valid, tok_type, tok_arg, input tok_ready);
    modport slave  (input tok_valid, tok_type, tok_arg, output tok_ready);
endinterface

// File: rtl/rpn_checker.sv
// Evaluates a player's Reverse-Polish answer for the dealt four-card set on a 4-deep signed
// stack, reporting a win or the first sticky error code.
module rpn_checker #(
    parameter int NUM_W  = 10,
    parameter int ACC_W  = 16,
    parameter int TARGET = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num1,
    input  logic [NUM_W-1:0] num2,
    input  logic [NUM_W-1:0] num3,
    input  logic [NUM_W-1:0] num4,
    input  logic             submit,
    rpn_checker_if.slave     tok,
    output logic             busy,
    output logic [3:0]       used_mask,
    output logic             result_valid,
    output logic             result_win,
    output logic [2:0]       err_code
);
    typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_EXEC, S_DIV, S_CHECK, S_REPORT} state_t;
    typedef enum logic [2:0] {
        E_NONE, E_REUSE, E_UNDER, E_OVER, E_DIVZ, E_INEXACT, E_INCOMPLETE, E_ARITH
    } err_t;

    localparam int               CNT_W    = $clog2(ACC_W + 1);
    localparam logic [ACC_W-1:0] TARGET_V = ACC_W'(TARGET);

    state_t           state_q, state_d;
    err_t             err_q, err_d;
    logic [NUM_W-1:0] card_q [4];
    logic [NUM_W-1:0] card_d [4];
    logic [ACC_W-1:0] stk_q [4];
    logic [ACC_W-1:0] stk_d [4];
    logic [2:0]       depth_q, depth_d;
    logic [3:0]       mask_q, mask_d;
    logic [1:0]       op_q, op_d;
    logic [ACC_W-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
    logic [ACC_W:0]   rem_q, rem_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             win_q, win_d;

    logic             tok_fire, op_ok;
    logic [1:0]       top_idx, sec_idx;
    logic [ACC_W-1:0] top_v, sec_v, quo_signed;
    logic [2*ACC_W-1:0] wide_a, wide_b, wide_res;
    logic             res_fits, quo_ovf;
    logic [ACC_W:0]   div_shift, div_trial;

    function automatic logic [ACC_W-1:0] mag(input logic [ACC_W-1:0] v);
        return v[ACC_W-1] ? -v : v;
    endfunction

    // submit takes priority over a coincident token
    assign tok_fire = (state_q == S_ACCEPT) && tok.tok_valid && !submit;
    assign op_ok    = (err_q == E_NONE) && (depth_q >= 3'd2);
    assign top_idx  = depth_q[1:0] - 2'd1;
    assign sec_idx  = depth_q[1:0] - 2'd2;
    assign top_v    = stk_q[top_idx];
    assign sec_v    = stk_q[sec_idx];

    assign wide_a   = {{ACC_W{sec_v[ACC_W-1]}}, sec_v};
    assign wide_b   = {{ACC_W{top_v[ACC_W-1]}}, top_v};
    assign res_fits = (&wide_res[2*ACC_W-1:ACC_W-1]) || (~|wide_res[2*ACC_W-1:ACC_W-1]);

    // dvd_q shifts out dividend bits and shifts in quotient bits
    assign div_shift  = {rem_q[ACC_W-1:0], dvd_q[ACC_W-1]};
    assign div_trial  = div_shift - {1'b0, dvs_q};
    assign quo_signed = neg_q ? -dvd_q : dvd_q;
    assign quo_ovf    = !neg_q && dvd_q[ACC_W-1];

    always_comb begin
        wide_res = '0;
        case (op_q)
            2'b00:   wide_res = wide_a + wide_b;
            2'b01:   wide_res = wide_a - wide_b;
            default: wide_res = wide_a * wide_b;
        endcase
    end

    // NOTE: every register in the block lives in this one process and is updated with <=,
    // so all _q values read by the combinational logic are the pre-edge ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            err_q   <= E_NONE;
            card_q  <= '{default: '0};
            // NOTE: the stack is four plain flops, so it is cleared with the rest of the
            // state; a RAM-backed stack would rely on depth_q alone instead.
            stk_q   <= '{default: '0};
            depth_q <= '0;
            mask_q  <= '0;
            op_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            card_q  <= card_d;
            stk_q   <= stk_d;
            depth_q <= depth_d;
            mask_q  <= mask_d;
            op_q    <= op_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACCEPT: begin
                if (submit)
                    state_d = S_CHECK;
                else if (tok_fire && tok.tok_type && op_ok)
                    state_d = (tok.tok_arg == 2'b11) ? S_DIV : S_EXEC;
            end
            S_EXEC:   state_d = S_ACCEPT;
            S_DIV: begin
                if ((cnt_q == '0 && dvs_q == '0) || cnt_q == CNT_W'(ACC_W))
                    state_d = S_ACCEPT;
            end
            S_CHECK:  state_d = S_REPORT;
            S_IDLE, S_REPORT: state_d = state_q;
            default:  state_d = S_IDLE;
        endcase
        if (start)
            state_d = S_ACCEPT;
    end

    // NOTE: each _d starts as its _q so no path through the case leaves a value unassigned;
    // without these defaults the process would infer latches.
    always_comb begin
        err_d   = err_q;
        card_d  = card_q;
        stk_d   = stk_q;
        depth_d = depth_q;
        mask_d  = mask_q;
        op_d    = op_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        if (start) begin
            card_d  = '{num1, num2, num3, num4};
            stk_d   = '{default: '0};
            depth_d = '0;
            mask_d  = '0;
            err_d   = E_NONE;
            cnt_d   = '0;
            win_d   = 1'b0;
        end else begin
            case (state_q)
                S_ACCEPT: begin
                    if (tok_fire && err_q == E_NONE) begin
                        if (!tok.tok_type) begin
                            if (mask_q[tok.tok_arg])
                                err_d = E_REUSE;
                            else if (depth_q == 3'd4)
                                err_d = E_OVER;
                            else begin
                                stk_d[depth_q[1:0]]  = ACC_W'(card_q[tok.tok_arg]);
                                depth_d              = depth_q + 3'd1;
                                mask_d[tok.tok_arg]  = 1'b1;
                            end
                        end else if (depth_q < 3'd2) begin
                            err_d = E_UNDER;
                        end else begin
                            op_d  = tok.tok_arg;
                            dvd_d = mag(sec_v);
                            dvs_d = mag(top_v);
                            neg_d = sec_v[ACC_W-1] ^ top_v[ACC_W-1];
                            rem_d = '0;
                            cnt_d = '0;
                        end
                    end
                end
                S_EXEC: begin
                    if (res_fits) begin
                        stk_d[sec_idx] = wide_res[ACC_W-1:0];
                        depth_d        = depth_q - 3'd1;
                    end else begin
                        err_d = E_ARITH;
                    end
                end
                S_DIV: begin
                    if (cnt_q == '0 && dvs_q == '0) begin
                        err_d = E_DIVZ;
                    end else if (cnt_q == CNT_W'(ACC_W)) begin
                        if (rem_q != '0)
                            err_d = E_INEXACT;
                        else if (quo_ovf)
                            err_d = E_ARITH;
                        else begin
                            stk_d[sec_idx] = quo_signed;
                            depth_d        = depth_q - 3'd1;
                        end
                    end else begin
                        if (!div_trial[ACC_W]) begin
                            rem_d = div_trial;
                            dvd_d = {dvd_q[ACC_W-2:0], 1'b1};
                        end else begin
                            rem_d = div_shift;
                            dvd_d = {dvd_q[ACC_W-2:0], 1'b0};
                        end
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (err_q == E_NONE && (mask_q != 4'hf || depth_q != 3'd1))
                        err_d = E_INCOMPLETE;
                    win_d = (err_d == E_NONE) && (top_v == TARGET_V);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tok.tok_ready = (state_q == S_ACCEPT);
        busy          = (state_q == S_EXEC) || (state_q == S_DIV) || (state_q == S_CHECK);
        result_valid  = (state_q == S_REPORT);
        result_win    = (state_q == S_REPORT) && win_q;
        used_mask     = mask_q;
        err_code      = err_q;
    end
endmodule

// File: tb/tb_rpn_checker.sv
// Self-checking bench for rpn_checker: directed scenarios plus randomized token streams
// scored against a queue-based RPN evaluator.
module tb_rpn_checker;
    localparam int NUM_W   = 10;
    localparam int ACC_W   = 16;
    localparam int TARGET  = 24;
    localparam int DIV_LAT = ACC_W + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             submit = 1'b0;
    logic [NUM_W-1:0] num1 = '0, num2 = '0, num3 = '0, num4 = '0;
    logic             busy, result_valid, result_win;
    logic [3:0]       used_mask;
    logic [2:0]       err_code;

    rpn_checker_if tok_if ();

    rpn_checker #(.NUM_W(NUM_W), .ACC_W(ACC_W), .TARGET(TARGET)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .num1(num1), .num2(num2), .num3(num3), .num4(num4),
        .submit(submit), .tok(tok_if), .busy(busy), .used_mask(used_mask),
        .result_valid(result_valid), .result_win(result_win), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain RPN evaluation on a queue with wide integer arithmetic
    int         m_card [4];
    int         m_st [$];
    int         m_err;
    logic [3:0] m_mask;
    logic       m_win;

    task automatic m_start(input int c0, input int c1, input int c2, input int c3);
        m_card = '{c0, c1, c2, c3};
        m_st.delete();
        m_err  = 0;
        m_mask = 4'h0;
        m_win  = 1'b0;
    endtask

    task automatic m_tok(input logic t, input logic [1:0] a);
        longint x, y, r;
        longint lim;
        lim = longint'(1) << (ACC_W - 1);
        if (m_err != 0) return;
        if (!t) begin
            if (m_mask[a]) m_err = 1;
            else if (m_st.size() == 4) m_err = 3;
            else begin
                m_st.push_back(m_card[a]);
                m_mask[a] = 1'b1;
            end
            return;
        end
        if (m_st.size() < 2) begin
            m_err = 2;
            return;
        end
        x = m_st[m_st.size() - 2];
        y = m_st[m_st.size() - 1];
        case (a)
            2'd0: r = x + y;
            2'd1: r = x - y;
            2'd2: r = x * y;
            default: begin
                if (y == 0) begin m_err = 4; return; end
                if (x % y != 0) begin m_err = 5; return; end
                r = x / y;
            end
        endcase
        if (r < -lim || r >= lim) begin
            m_err = 7;
            return;
        end
        void'(m_st.pop_back());
        void'(m_st.pop_back());
        m_st.push_back(int'(r));
    endtask

    task automatic m_submit();
        if (m_err == 0 && (m_mask != 4'hf || m_st.size() != 1)) m_err = 6;
        m_win = (m_err == 0) && (m_st[0] == TARGET);
    endtask

    // Stimulus helpers: each begins and ends just after a falling edge
    task automatic do_start(input int c0, input int c1, input int c2, input int c3);
        num1  = NUM_W'(c0);
        num2  = NUM_W'(c1);
        num3  = NUM_W'(c2);
        num4  = NUM_W'(c3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num1  = NUM_W'($urandom);
        num2  = NUM_W'($urandom);
        num3  = NUM_W'($urandom);
        num4  = NUM_W'($urandom);
        m_start(c0, c1, c2, c3);
    endtask

    task automatic send_tok(input logic t, input logic [1:0] a, output int lat, output logic bsy);
        int waitc = 0;
        tok_if.tok_valid = 1'b1;
        tok_if.tok_type  = t;
        tok_if.tok_arg   = a;
        while (!tok_if.tok_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!tok_if.tok_ready) begin
            bad++;
            $display("FAIL tok_accept_timeout: tok_ready=0 required 1");
        end
        total++;
        @(negedge clk);
        tok_if.tok_valid = 1'b0;
        bsy = busy;
        lat = 0;
        while (!tok_if.tok_ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        m_tok(t, a);
    endtask

    // Tokens encoded as 0..3 push slot, 4 add, 5 sub, 6 mul, 7 div
    task automatic play(input int seq [$], output int lats [$], output logic bsys [$]);
        int   lat;
        logic bsy;
        lats.delete();
        bsys.delete();
        foreach (seq[i]) begin
            send_tok(seq[i] >= 4, 2'(seq[i] % 4), lat, bsy);
            lats.push_back(lat);
            bsys.push_back(bsy);
        end
    endtask

    task automatic do_submit(output int lat);
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        lat = 1;
        while (!result_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        m_submit();
    endtask

    int   seq [$];
    int   lats [$];
    logic bsys [$];
    int   slat;

    task automatic test_reset();
        #12;
        if ({tok_if.tok_ready, busy, used_mask, result_valid, result_win, err_code} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {tok_if.tok_ready, busy, used_mask, result_valid, result_win, err_code});
        end
        total++;
        @(negedge clk);
        rst_n = 1'b1;
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        if ({tok_if.tok_ready, result_valid} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset: ready/valid=%b required 00", {tok_if.tok_ready, result_valid});
        end
        total++;
    endtask

    task automatic test_win();
        do_start(2, 4, 8, 10);
        seq = '{3, 0, 6, 2, 4, 1, 5};
        play(seq, lats, bsys);
        if ({lats[0], lats[2]} !== {32'd0, 32'd1} || {bsys[0], bsys[2]} !== 2'b01) begin
            bad++;
            $display("FAIL win_latency: push lat=%0d busy=%b, mul lat=%0d busy=%b; required 0/0, 1/1",
                     lats[0], bsys[0], lats[2], bsys[2]);
        end
        total++;
        do_submit(slat);
        if (slat !== 2) begin
            bad++;
            $display("FAIL submit_latency: got %0d required 2", slat);
        end
        total++;
        if ({result_valid, result_win, err_code, used_mask} !== {1'b1, 1'b1, 3'd0, 4'hf}) begin
            bad++;
            $display("FAIL win_result: got v=%b w=%b e=%0d m=%b required 1 1 0 1111",
                     result_valid, result_win, err_code, used_mask);
        end
        total++;
    endtask

    task automatic test_exact_div();
        do_start(1, 3, 7, 12);
        seq = '{3, 1, 7, 2, 0, 5, 6};
        play(seq, lats, bsys);
        if (lats[2] !== DIV_LAT || bsys[2] !== 1'b1) begin
            bad++;
            $display("FAIL div_latency: ready low %0d cycles busy=%b required %0d and 1",
                     lats[2], bsys[2], DIV_LAT);
        end
        total++;
        do_submit(slat);
        if ({result_valid, result_win, err_code} !== {1'b1, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL div_win: got v=%b w=%b e=%0d required 1 1 0", result_valid, result_win, err_code);
        end
        total++;
    endtask

    task automatic test_errors();
        do_start(1, 3, 7, 12);
        seq = '{2, 2};
        play(seq, lats, bsys);
        if ({err_code, used_mask} !== {3'd1, 4'b0100}) begin
            bad++;
            $display("FAIL reuse: got e=%0d m=%b required 1 0100", err_code, used_mask);
        end
        total++;
        seq = '{0, 1, 6, 3, 5};
        play(seq, lats, bsys);
        do_submit(slat);
        if ({result_valid, result_win, err_code, used_mask} !== {1'b1, 1'b0, 3'd1, 4'b0100}) begin
            bad++;
            $display("FAIL sticky_reuse: got v=%b w=%b e=%0d m=%b required 1 0 1 0100",
                     result_valid, result_win, err_code, used_mask);
        end
        total++;
        do_start(4, 6, 7, 9);
        seq = '{2, 0, 7};
        play(seq, lats, bsys);
        if ({err_code, lats[2]} !== {3'd5, DIV_LAT}) begin
            bad++;
            $display("FAIL inexact_div: got e=%0d lat=%0d required 5 %0d", err_code, lats[2], DIV_LAT);
        end
        total++;
        do_start(1000, 999, 2, 3);
        seq = '{0, 1, 6};
        play(seq, lats, bsys);
        if ({err_code, used_mask} !== {3'd7, 4'b0011}) begin
            bad++;
            $display("FAIL mul_overflow: got e=%0d m=%b required 7 0011", err_code, used_mask);
        end
        total++;
    endtask

    task automatic test_div_zero();
        do_start(3, 6, 6, 11);
        seq = '{3, 1, 2, 5, 7};
        play(seq, lats, bsys);
        if ({err_code, lats[4]} !== {3'd4, 32'd1}) begin
            bad++;
            $display("FAIL div_zero: got e=%0d lat=%0d required 4 1", err_code, lats[4]);
        end
        total++;
        do_start(3, 6, 6, 11);
        seq = '{4};
        play(seq, lats, bsys);
        if ({err_code, used_mask} !== {3'd2, 4'b0000}) begin
            bad++;
            $display("FAIL underflow: got e=%0d m=%b required 2 0000", err_code, used_mask);
        end
        total++;
    endtask

    task automatic test_incomplete();
        do_start(7, 8, 9, 10);
        seq = '{0, 1, 4};
        play(seq, lats, bsys);
        do_submit(slat);
        if ({result_valid, result_win, err_code, used_mask} !== {1'b1, 1'b0, 3'd6, 4'b0011}) begin
            bad++;
            $display("FAIL incomplete: got v=%b w=%b e=%0d m=%b required 1 0 6 0011",
                     result_valid, result_win, err_code, used_mask);
        end
        total++;
        do_start(7, 8, 9, 10);
        seq = '{0, 1, 2, 3, 0};
        play(seq, lats, bsys);
        if ({err_code, used_mask} !== {3'd1, 4'hf}) begin
            bad++;
            $display("FAIL full_stack_push: got e=%0d m=%b required 1 1111", err_code, used_mask);
        end
        total++;
    endtask

    task automatic test_back_to_back();
        do_start(2, 4, 8, 10);
        if ({result_valid, tok_if.tok_ready} !== 2'b01) begin
            bad++;
            $display("FAIL restart_from_report: valid/ready=%b required 01", {result_valid, tok_if.tok_ready});
        end
        total++;
        seq = '{3, 0, 6, 2, 4, 1, 5};
        play(seq, lats, bsys);
        tok_if.tok_valid = 1'b1;
        tok_if.tok_type  = 1'b0;
        tok_if.tok_arg   = 2'd0;
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        tok_if.tok_valid = 1'b0;
        @(negedge clk);
        if ({result_valid, result_win, err_code, used_mask} !== {1'b1, 1'b1, 3'd0, 4'hf}) begin
            bad++;
            $display("FAIL submit_beats_token: got v=%b w=%b e=%0d m=%b required 1 1 0 1111",
                     result_valid, result_win, err_code, used_mask);
        end
        total++;
    endtask

    task automatic test_restart_mid_div();
        do_start(1, 3, 7, 12);
        seq = '{3, 1};
        play(seq, lats, bsys);
        tok_if.tok_valid = 1'b1;
        tok_if.tok_type  = 1'b1;
        tok_if.tok_arg   = 2'd3;
        @(negedge clk);
        tok_if.tok_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        if ({tok_if.tok_ready, busy, used_mask, result_valid, result_win, err_code} !== 11'd0) begin
            bad++;
            $display("FAIL reset_mid_div: got %b required all zero",
                     {tok_if.tok_ready, busy, used_mask, result_valid, result_win, err_code});
        end
        total++;
        @(negedge clk);
        rst_n = 1'b1;
        do_start(1, 3, 7, 12);
        seq = '{3, 1};
        play(seq, lats, bsys);
        tok_if.tok_valid = 1'b1;
        tok_if.tok_type  = 1'b1;
        tok_if.tok_arg   = 2'd3;
        @(negedge clk);
        tok_if.tok_valid = 1'b0;
        repeat (4) @(negedge clk);
        do_start(2, 4, 8, 10);
        if ({tok_if.tok_ready, busy, result_valid, used_mask, err_code} !== {1'b1, 1'b0, 1'b0, 4'h0, 3'd0}) begin
            bad++;
            $display("FAIL start_mid_div: got rdy=%b busy=%b v=%b m=%b e=%0d required 1 0 0 0000 0",
                     tok_if.tok_ready, busy, result_valid, used_mask, err_code);
        end
        total++;
        seq = '{3, 0, 6, 2, 4, 1, 5};
        play(seq, lats, bsys);
        do_submit(slat);
        if ({result_valid, result_win, err_code} !== {1'b1, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL win_after_restart: got v=%b w=%b e=%0d required 1 1 0",
                     result_valid, result_win, err_code);
        end
        total++;
    endtask

    task automatic test_random();
        int   c [4];
        int   mode, n, lat;
        logic t, bsy;
        logic [1:0] a;
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(2, 0));
            for (int i = 0; i < 4; i++) begin
                case (mode)
                    0:       c[i] = int'($urandom_range(13, 1));
                    1:       c[i] = int'($urandom_range(1023, 0));
                    default: c[i] = int'($urandom_range(3, 0));
                endcase
            end
            do_start(c[0], c[1], c[2], c[3]);
            n = int'($urandom_range(10, 4));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(3, 0) != 0 && m_err == 0) begin
                    if (m_mask != 4'hf && (m_st.size() < 2 || $urandom_range(1, 0) == 1)) begin
                        t = 1'b0;
                        do a = 2'($urandom_range(3, 0)); while (m_mask[a]);
                    end else begin
                        t = 1'b1;
                        a = 2'($urandom_range(3, 0));
                    end
                end else begin
                    t = 1'($urandom_range(1, 0));
                    a = 2'($urandom_range(3, 0));
                end
                send_tok(t, a, lat, bsy);
                if ({err_code, used_mask} !== {3'(m_err), m_mask}) begin
                    bad++;
                    $display("FAIL rand_tok it=%0d k=%0d: got e=%0d m=%b required e=%0d m=%b",
                             it, k, err_code, used_mask, m_err, m_mask);
                end
                total++;
            end
            do_submit(lat);
            if ({result_valid, result_win, err_code, used_mask} !== {1'b1, m_win, 3'(m_err), m_mask}) begin
                bad++;
                $display("FAIL rand_result it=%0d: got v=%b w=%b e=%0d m=%b required 1 %b %0d %b",
                         it, result_valid, result_win, err_code, used_mask, m_win, m_err, m_mask);
            end
            total++;
        end
    endtask

    initial begin
        tok_if.tok_valid = 1'b0;
        tok_if.tok_type  = 1'b0;
        tok_if.tok_arg   = 2'd0;
        test_reset();
        test_win();
        test_exact_div();
        test_errors();
        test_div_zero();
        test_incomplete();
        test_back_to_back();
        test_restart_mid_div();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
